// File: rtl/aes_inv_key_schedule_pkg.sv
// Shared definitions for the AES-128 inverse key schedule and the encryption
// path: FSM state encoding, round constants, the forward S-box table and the
// default round count.
package aes_inv_key_schedule_pkg;

  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // Round constants for rounds 1..10 (entry 0 belongs to round 1).
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Forward AES S-box, indexed by the input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant byte for round 1..10; zero outside that range.
  function automatic logic [7:0] rcon_byte(input logic [3:0] round);
    logic [3:0] idx;
    idx = round - 4'd1;
    if (round == 4'd0 || round > 4'd10) begin
      return 8'h00;
    end
    return RCON[idx];
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_sub_word.sv
// aes_sub_word: AES SubWord, four independent forward S-box lookups.
// Purely combinational so it can be shared with the encryption datapath.
// Ports:
//   word  - 32-bit input word
//   subst - S-box substituted word, byte for byte
module aes_sub_word
  import aes_inv_key_schedule_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subst
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign subst[8*gi +: 8] = SBOX[word[8*gi +: 8]];
  end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: expands an AES-128 cipher key one round key per
// cycle into local storage, then delivers the round keys in decryption order
// (NR down to 0), stepping on each RK_ADV and wrapping back to NR so the next
// block can reuse the schedule.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   KEY_LOAD/CIPHER_KEY - request to expand a new key (ignored while BUSY)
//   RK_ADV              - step to the next round key (READY only)
//   BUSY                - expansion in progress
//   RK_VALID            - RK_OUT/RK_IDX hold a valid round key
//   RK_OUT/RK_IDX       - current round key and its round index
//   RK_LAST             - RK_IDX is 0, the final AddRoundKey key
module aes_inv_key_schedule
  import aes_inv_key_schedule_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         KEY_LOAD,
  input  logic [127:0] CIPHER_KEY,
  input  logic         RK_ADV,
  output logic         BUSY,
  output logic         RK_VALID,
  output logic [127:0] RK_OUT,
  output logic [3:0]   RK_IDX,
  output logic         RK_LAST
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t       state_reg;
  logic [3:0]   cnt_reg;
  logic [3:0]   ptr_reg;
  logic [127:0] key_mem [0:NR];

  logic         load_ok;
  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  logic [31:0]  prev_w [4];
  logic [31:0]  next_w [4];
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  mix_word;
  logic [127:0] next_key;
  logic [3:0]   ptr_next;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [127:0] wr_data;

  assign load_ok  = KEY_LOAD && (state_reg != EXPAND);
  assign prev_idx = cnt_reg - 4'd1;
  assign prev_key = key_mem[prev_idx];

  // Word 0 sits in the top 32 bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_split
    assign prev_w[gi] = prev_key[127 - 32*gi -: 32];
    assign next_key[127 - 32*gi -: 32] = next_w[gi];
  end

  assign rot_word = {prev_w[3][23:0], prev_w[3][31:24]};

  aes_sub_word u_sub_word (
    .word  (rot_word),
    .subst (sub_word)
  );

  assign mix_word = sub_word ^ {rcon_byte(cnt_reg), 24'h000000};

  // Each new word chains off the one just produced in the same round key.
  assign next_w[0] = prev_w[0] ^ mix_word;
  for (genvar gi = 1; gi < 4; gi++) begin : g_chain
    assign next_w[gi] = prev_w[gi] ^ next_w[gi-1];
  end

  assign ptr_next = (ptr_reg == 4'd0) ? LAST_IDX : ptr_reg - 4'd1;

  // Single write port: cipher key into slot 0 on load, then one round key per
  // expansion cycle.
  assign wr_en   = rst_n && (load_ok || state_reg == EXPAND);
  assign wr_addr = (state_reg == EXPAND) ? cnt_reg : 4'd0;
  assign wr_data = (state_reg == EXPAND) ? next_key : CIPHER_KEY;

  // Storage is not reset: it is only read once a full expansion has
  // completed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      ptr_reg   <= 4'd0;
      BUSY      <= 1'b0;
      RK_VALID  <= 1'b0;
      RK_LAST   <= 1'b0;
      RK_OUT    <= 128'd0;
    end else begin
      case (state_reg)
        IDLE, READY: begin
          if (KEY_LOAD) begin
            state_reg <= EXPAND;
            cnt_reg   <= 4'd1;
            BUSY      <= 1'b1;
            RK_VALID  <= 1'b0;
            RK_LAST   <= 1'b0;
          end else if (state_reg == READY && RK_ADV) begin
            ptr_reg <= ptr_next;
            RK_OUT  <= key_mem[ptr_next];
            RK_LAST <= (ptr_next == 4'd0);
          end
        end
        EXPAND: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == LAST_IDX) begin
            // The last round key is not in storage yet, so forward it
            // straight to the output register.
            state_reg <= READY;
            ptr_reg   <= LAST_IDX;
            RK_OUT    <= next_key;
            RK_LAST   <= 1'b0;
            BUSY      <= 1'b0;
            RK_VALID  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign RK_IDX = ptr_reg;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         KEY_LOAD;
  logic [127:0] CIPHER_KEY;
  logic         RK_ADV;
  logic         BUSY;
  logic         RK_VALID;
  logic [127:0] RK_OUT;
  logic [3:0]   RK_IDX;
  logic         RK_LAST;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_inv_key_schedule dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .KEY_LOAD   (KEY_LOAD),
    .CIPHER_KEY (CIPHER_KEY),
    .RK_ADV     (RK_ADV),
    .BUSY       (BUSY),
    .RK_VALID   (RK_VALID),
    .RK_OUT     (RK_OUT),
    .RK_IDX     (RK_IDX),
    .RK_LAST    (RK_LAST)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk10;
    logic [127:0] rk1;
  } vec_t;

  vec_t         vecs [3];
  logic [127:0] fips_rk [11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance();
    RK_ADV = 1'b1;
    tick();
    RK_ADV = 1'b0;
  endtask

  // Load a key and follow the fixed 10-cycle expansion window to READY.
  task automatic load_and_wait(input logic [127:0] key, input string name);
    int busy_cycles;
    KEY_LOAD   = 1'b1;
    CIPHER_KEY = key;
    tick();
    KEY_LOAD   = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (BUSY === 1'b1 && RK_VALID === 1'b0) busy_cycles++;
      tick();
    end
    chk({name, " busy_cycles"}, 128'(busy_cycles), 128'(10));
    chk({name, " busy_low_at_ready"}, 128'(BUSY), 128'(0));
    chk({name, " valid_at_t11"}, 128'(RK_VALID), 128'(1));
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, " busy"},  128'(BUSY), 128'(0));
    chk({name, " valid"}, 128'(RK_VALID), 128'(0));
    chk({name, " last"},  128'(RK_LAST), 128'(0));
    chk({name, " idx"},   128'(RK_IDX), 128'(0));
    chk({name, " rk"},    RK_OUT, 128'd0);
  endtask

  initial begin
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h13111d7fe3944a17f307a78b4d2b30c5,
                128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[2] = '{128'h00000000000000000000000000000000,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                128'h62636363626363636263636362636363};

    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_n      = 1'b0;
    KEY_LOAD   = 1'b0;
    RK_ADV     = 1'b0;
    CIPHER_KEY = 128'd0;
    tick();
    tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // RK_ADV in IDLE must not move anything.
    advance();
    advance();
    check_outputs_zero("adv_in_idle");

    // Table-driven vectors: first key, rk1, rk0, and the wrap.
    for (int v = 0; v < 3; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      load_and_wait(vecs[v].key, tag);
      chk({tag, " rk10"}, RK_OUT, vecs[v].rk10);
      chk({tag, " idx10"}, 128'(RK_IDX), 128'(10));
      chk({tag, " last_at10"}, 128'(RK_LAST), 128'(0));
      for (int a = 0; a < 9; a++) advance();
      chk({tag, " rk1"}, RK_OUT, vecs[v].rk1);
      chk({tag, " idx1"}, 128'(RK_IDX), 128'(1));
      advance();
      chk({tag, " rk0"}, RK_OUT, vecs[v].key);
      chk({tag, " idx0"}, 128'(RK_IDX), 128'(0));
      chk({tag, " last_at0"}, 128'(RK_LAST), 128'(1));
      advance();
      chk({tag, " wrap_idx"}, 128'(RK_IDX), 128'(10));
      chk({tag, " wrap_rk"}, RK_OUT, vecs[v].rk10);
      chk({tag, " wrap_last"}, 128'(RK_LAST), 128'(0));
    end

    // Full walk of the FIPS-197 schedule with a hold in the middle.
    load_and_wait(fips_rk[0], "walk");
    chk("walk rk10", RK_OUT, fips_rk[10]);
    for (int r = 9; r >= 0; r--) begin
      advance();
      chk($sformatf("walk idx%0d", r), 128'(RK_IDX), 128'(r));
      chk($sformatf("walk rk%0d", r), RK_OUT, fips_rk[r]);
      chk($sformatf("walk last%0d", r), 128'(RK_LAST), 128'(r == 0));
      if (r == 5) begin
        tick();
        tick();
        tick();
        chk("hold idx", 128'(RK_IDX), 128'(5));
        chk("hold rk", RK_OUT, fips_rk[5]);
        chk("hold valid", 128'(RK_VALID), 128'(1));
      end
    end

    // KEY_LOAD pulses at T+3 and T+7 with a different key are ignored.
    KEY_LOAD   = 1'b1;
    CIPHER_KEY = vecs[1].key;
    tick();
    KEY_LOAD   = 1'b0;
    tick();
    tick();
    KEY_LOAD   = 1'b1;
    CIPHER_KEY = vecs[0].key;
    tick();
    KEY_LOAD   = 1'b0;
    tick();
    tick();
    tick();
    KEY_LOAD   = 1'b1;
    tick();
    KEY_LOAD   = 1'b0;
    chk("ignload busy_t8", 128'(BUSY), 128'(1));
    tick();
    tick();
    chk("ignload busy_t10", 128'(BUSY), 128'(1));
    tick();
    chk("ignload valid_t11", 128'(RK_VALID), 128'(1));
    chk("ignload rk10", RK_OUT, vecs[1].rk10);
    for (int a = 0; a < 10; a++) advance();
    chk("ignload rk0", RK_OUT, vecs[1].key);

    // Reset at T+5 abandons the schedule.
    KEY_LOAD   = 1'b1;
    CIPHER_KEY = vecs[0].key;
    tick();
    KEY_LOAD   = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_outputs_zero("midreset");
    begin
      int valid_seen;
      valid_seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (RK_VALID !== 1'b0 || BUSY !== 1'b0) valid_seen++;
        tick();
      end
      chk("midreset stays_idle", 128'(valid_seen), 128'(0));
    end
    load_and_wait(vecs[2].key, "postreset");
    chk("postreset rk10", RK_OUT, vecs[2].rk10);

    // KEY_LOAD and RK_ADV together in READY: load wins.
    KEY_LOAD   = 1'b1;
    RK_ADV     = 1'b1;
    CIPHER_KEY = vecs[0].key;
    tick();
    KEY_LOAD   = 1'b0;
    RK_ADV     = 1'b0;
    chk("both busy", 128'(BUSY), 128'(1));
    chk("both valid", 128'(RK_VALID), 128'(0));
    for (int i = 0; i < 9; i++) tick();
    chk("both busy_t10", 128'(BUSY), 128'(1));
    tick();
    chk("both valid_t11", 128'(RK_VALID), 128'(1));
    chk("both idx10", 128'(RK_IDX), 128'(10));
    chk("both rk10", RK_OUT, vecs[0].rk10);
    advance();
    chk("both rk9", RK_OUT, fips_rk[9]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_schedule.md
AES_INV_KEY_SCHEDULE -- requirements
Module: aes_inv_key_schedule

Interface
REQ-001 The module SHALL have parameter NR, default 10, giving the number of AES-128 rounds (round keys 0..NR are stored).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The module SHALL have port KEY_LOAD, input, 1 bit: a one-cycle request to expand CIPHER_KEY.
REQ-005 The module SHALL have port CIPHER_KEY, input, 128 bits: the cipher key, sampled only on an accepted KEY_LOAD; bits [127:96] are word w0 (FIPS-197 byte order).
REQ-006 The module SHALL have port RK_ADV, input, 1 bit: the consumer's pulse to step to the next round key.
REQ-007 The module SHALL have port BUSY, output, 1 bit: high while expansion is in progress.
REQ-008 The module SHALL have port RK_VALID, output, 1 bit: high when RK_OUT holds a valid round key.
REQ-009 The module SHALL have port RK_OUT, output, 128 bits: the current round key, XORed by the decryption round with its data.
REQ-010 The module SHALL have port RK_IDX, output, 4 bits: the round index of RK_OUT.
REQ-011 The module SHALL have port RK_LAST, output, 1 bit: high when RK_IDX = 0, i.e. the final AddRoundKey key.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, EXPAND and READY.
REQ-013 In IDLE or READY, KEY_LOAD=1 SHALL capture CIPHER_KEY as key[0], set cnt=1 and enter EXPAND.
REQ-014 Each EXPAND cycle SHALL compute key[cnt] from key[cnt-1] and then increment cnt: w[i] = w[i-4] ^ (i%4==0 ? SubWord(RotWord(w[i-1])) ^ Rcon : w[i-1]).
REQ-015 Rcon SHALL take the byte sequence 01,02,04,08,10,20,40,80,1b,36 for cnt = 1..10, placed in the most significant byte of the word.
REQ-016 After the cycle in which key[NR] is written, the FSM SHALL enter READY; KEY_LOAD accepted in cycle T yields EXPAND in cycles T+1..T+NR and READY from T+NR+1.
REQ-017 BUSY SHALL be high exactly while in EXPAND.
REQ-018 RK_VALID SHALL be high exactly while in READY.
REQ-019 On entry to READY, the read pointer SHALL be set to NR, so keys are delivered in decryption order NR..0.
REQ-020 RK_OUT SHALL equal key[ptr], registered, and RK_IDX SHALL equal ptr.
REQ-021 RK_ADV=1 in READY SHALL decrement ptr, with the new key visible the next cycle.
REQ-022 RK_ADV=1 with ptr=0 SHALL wrap ptr to NR so the next block reuses the schedule without re-expansion.
REQ-023 KEY_LOAD=1 and RK_ADV=1 in the same READY cycle SHALL give KEY_LOAD priority: restart expansion and ignore RK_ADV.
REQ-024 KEY_LOAD during EXPAND SHALL be ignored, with no restart and no queuing.
REQ-025 RK_ADV outside READY SHALL be ignored.
REQ-026 RK_OUT and RK_IDX SHALL be held stable while RK_ADV=0.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, cnt=0, ptr=0, BUSY=0, RK_VALID=0, RK_LAST=0, RK_OUT=0 and RK_IDX=0, overriding KEY_LOAD and RK_ADV.
REQ-028 Reset during EXPAND or READY SHALL abandon the schedule; RK_VALID SHALL stay low until a new expansion completes.
REQ-029 The key storage array SHALL need no reset, because it is never read while RK_VALID=0.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the Rcon table, the AES S-box constant table and NR_AES128=10.
REQ-031 The SubWord function SHALL be one sub-module, aes_sub_word: four forward S-box lookups, combinational, reusable by the encryption path.
REQ-032 Key storage SHALL be an (NR+1) x 128-bit register array with one write port (cnt) and one read port (ptr).

Verification
REQ-033 CIPHER_KEY=2b7e151628aed2a6abf7158809cf4f3c with KEY_LOAD at T SHALL give BUSY high for T+1..T+10, then at T+11 RK_VALID=1, RK_IDX=10 and RK_OUT=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 For the same key, nine RK_ADV pulses SHALL give RK_IDX=1 with RK_OUT=a0fafe1788542cb123a339392a6c7605; one more pulse SHALL give RK_IDX=0, RK_LAST=1 and RK_OUT = the cipher key; one more SHALL wrap to RK_IDX=10.
REQ-035 CIPHER_KEY=000102030405060708090a0b0c0d0e0f SHALL give RK_OUT=13111d7fe3944a17f307a78b4d2b30c5 at RK_IDX=10.
REQ-036 KEY_LOAD pulses at T+3 and T+7 during EXPAND SHALL be ignored, with READY still reached at T+11 with unchanged keys.
REQ-037 rst_n=0 at T+5 SHALL give IDLE with all outputs 0 at T+6; a subsequent KEY_LOAD SHALL complete normally.
REQ-038 KEY_LOAD and RK_ADV asserted together in READY SHALL give BUSY=1 next cycle, RK_VALID=0 and the new schedule.
